// File: rtl/gfx_cmd_queue.sv
// Command FIFO and sequencer feeding graphics_processor: queues draw commands and
// issues them one at a time, holding gp_en until gp_finish and forcing a low gap.
package gfx_cmd_queue_pkg;

    typedef struct packed {
        logic        opcode;
        logic [9:0]  tl_x;
        logic [8:0]  tl_y;
        logic [9:0]  br_x;
        logic [8:0]  br_y;
        logic [11:0] arg;
    } gfx_cmd_t;

endpackage

module gfx_cmd_queue
    import gfx_cmd_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_opcode,
    input  logic [9:0]    cmd_tl_x,
    input  logic [8:0]    cmd_tl_y,
    input  logic [9:0]    cmd_br_x,
    input  logic [8:0]    cmd_br_y,
    input  logic [11:0]   cmd_arg,
    output logic          gp_en,
    output logic          gp_opcode,
    output logic [9:0]    gp_tl_x,
    output logic [8:0]    gp_tl_y,
    output logic [9:0]    gp_br_x,
    output logic [8:0]    gp_br_y,
    output logic [11:0]   gp_arg,
    input  logic          gp_finish,
    output logic          cmd_done,
    output logic [AW:0]   count,
    output logic          idle
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    gfx_cmd_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    state_t        state_q;
    state_t        state_d;
    gfx_cmd_t      cmd_in_c;
    gfx_cmd_t      gp_cmd_q;
    logic          push_c;
    logic          pop_c;
    logic          gp_en_d;
    logic          cmd_done_d;

    assign cmd_in_c = {cmd_opcode, cmd_tl_x, cmd_tl_y, cmd_br_x, cmd_br_y, cmd_arg};
    // cmd_ready is registered, so a push in the same cycle as a full-queue pop is refused
    assign push_c   = cmd_valid && cmd_ready;

    // Sequencer: pop in IDLE, hold in ISSUE until finish, one forced-low GAP cycle
    always_comb begin
        state_d    = state_q;
        gp_en_d    = 1'b0;
        cmd_done_d = 1'b0;
        pop_c      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop_c   = 1'b1;
                    gp_en_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (gp_finish) begin
                    cmd_done_d = 1'b1;
                    state_d    = ST_GAP;
                end else begin
                    gp_en_d = 1'b1;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array carries no reset; stale contents are unreachable once pointers clear
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr_q] <= cmd_in_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            gp_en     <= 1'b0;
            gp_cmd_q  <= '0;
            cmd_done  <= 1'b0;
            cmd_ready <= 1'b1;
            idle      <= 1'b1;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            gp_en     <= gp_en_d;
            cmd_done  <= cmd_done_d;
            cmd_ready <= (count_d != FULL_COUNT);
            idle      <= (count_d == '0) && (state_d == ST_IDLE);
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                gp_cmd_q <= mem[rd_ptr_q];
            end
        end
    end

    assign count     = count_q;
    assign gp_opcode = gp_cmd_q.opcode;
    assign gp_tl_x   = gp_cmd_q.tl_x;
    assign gp_tl_y   = gp_cmd_q.tl_y;
    assign gp_br_x   = gp_cmd_q.br_x;
    assign gp_br_y   = gp_cmd_q.br_y;
    assign gp_arg    = gp_cmd_q.arg;

endmodule

// File: tb/tb_gfx_cmd_queue.sv
// Randomised bench for gfx_cmd_queue against a queue-based reference model of the
// command FIFO and its issue timing (issue allowed two edges after each finish).
module tb_gfx_cmd_queue;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_opcode;
    logic [9:0]    cmd_tl_x;
    logic [8:0]    cmd_tl_y;
    logic [9:0]    cmd_br_x;
    logic [8:0]    cmd_br_y;
    logic [11:0]   cmd_arg;
    logic          gp_en;
    logic          gp_opcode;
    logic [9:0]    gp_tl_x;
    logic [8:0]    gp_tl_y;
    logic [9:0]    gp_br_x;
    logic [8:0]    gp_br_y;
    logic [11:0]   gp_arg;
    logic          gp_finish;
    logic          cmd_done;
    logic [AW:0]   count;
    logic          idle;

    gfx_cmd_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_tl_x(cmd_tl_x), .cmd_tl_y(cmd_tl_y),
        .cmd_br_x(cmd_br_x), .cmd_br_y(cmd_br_y), .cmd_arg(cmd_arg),
        .gp_en(gp_en), .gp_opcode(gp_opcode), .gp_tl_x(gp_tl_x), .gp_tl_y(gp_tl_y),
        .gp_br_x(gp_br_x), .gp_br_y(gp_br_y), .gp_arg(gp_arg),
        .gp_finish(gp_finish), .cmd_done(cmd_done), .count(count), .idle(idle)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [50:0] m_q[$];
    logic [50:0] m_cur;
    bit          m_busy;
    bit          m_done;
    int          cyc;
    int          next_issue;
    bit          last_push;
    int          done_seen;
    int          n_chk;
    int          n_pass;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [50:0] rnd_cmd();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[50:0];
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_cur      = '0;
        m_busy     = 1'b0;
        m_done     = 1'b0;
        next_issue = 0;
    endtask

    task automatic check_outputs();
        int k;
        k = cyc;
        check("gp_en",     64'(gp_en), 64'(m_busy));
        check("gp_fields", 64'({gp_opcode, gp_tl_x, gp_tl_y, gp_br_x, gp_br_y, gp_arg}), 64'(m_cur));
        check("cmd_done",  64'(cmd_done), 64'(m_done));
        check("count",     64'(count), 64'(m_q.size()));
        check("cmd_ready", 64'(cmd_ready), 64'(m_q.size() < DEPTH));
        check("idle",      64'(idle), 64'((m_q.size() == 0) && !m_busy && (k >= next_issue - 1)));
    endtask

    // One clock: drive inputs, advance model by the rules, sample 1 time unit after the edge
    task automatic tick(input bit v, input logic [50:0] d, input bit fin);
        bit push;
        bit pop;
        bit fin_eff;
        int k;
        cmd_valid = v;
        {cmd_opcode, cmd_tl_x, cmd_tl_y, cmd_br_x, cmd_br_y, cmd_arg} = d;
        gp_finish = fin;
        k       = cyc + 1;
        push    = v && (m_q.size() < DEPTH);
        pop     = !m_busy && (k >= next_issue) && (m_q.size() > 0);
        fin_eff = m_busy && fin;
        @(posedge clk);
        cyc    = k;
        m_done = fin_eff;
        if (fin_eff) begin
            m_busy     = 1'b0;
            next_issue = k + 2;
        end
        if (pop) begin
            m_cur  = m_q.pop_front();
            m_busy = 1'b1;
        end
        if (push) m_q.push_back(d);
        last_push = push;
        #1;
        if (cmd_done === 1'b1) done_seen++;
        check_outputs();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_gp_en", 64'(gp_en), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_idle",  64'(idle), 64'd1);
        check("rst_ready", 64'(cmd_ready), 64'd1);
        check("rst_done",  64'(cmd_done), 64'd0);
        check("rst_gp_fields", 64'({gp_opcode, gp_tl_x, gp_tl_y, gp_br_x, gp_br_y, gp_arg}), 64'd0);
        @(posedge clk);
        cyc++;
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while ((m_q.size() != 0 || m_busy) && n < maxc) begin
            tick(1'b0, '0, ($urandom_range(0, 2) == 0));
            n++;
        end
        check("drain_bounded", 64'(n < maxc), 64'd1);
        repeat (3) tick(1'b0, '0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [50:0] d1;
        logic [50:0] pend;
        int acc;
        int total_acc;
        int iter;
        n_chk = 0; n_pass = 0; cyc = 0; done_seen = 0; last_push = 0;
        cmd_valid = 0; gp_finish = 1'b1;
        {cmd_opcode, cmd_tl_x, cmd_tl_y, cmd_br_x, cmd_br_y, cmd_arg} = '0;
        rst_n = 1'b1;
        model_reset();
        #3;
        do_reset();

        // Single fill: issue one edge after the push edge, finish after 8 cycles
        d1 = {1'b0, 10'd10, 9'd20, 10'd13, 9'd21, 12'hF00};
        tick(1'b1, d1, 1'b0);
        check("t1_en_after_push", 64'(gp_en), 64'd0);
        tick(1'b0, '0, 1'b0);
        check("t1_en_issue", 64'(gp_en), 64'd1);
        check("t1_fields", 64'({gp_opcode, gp_tl_x, gp_tl_y, gp_br_x, gp_br_y, gp_arg}), 64'(d1));
        repeat (7) tick(1'b0, '0, 1'b0);
        done_seen = 0;
        tick(1'b0, '0, 1'b1);
        repeat (4) tick(1'b0, '0, 1'b0);
        check("t1_done_pulses", 64'(done_seen), 64'd1);
        check("t1_idle", 64'(idle), 64'd1);

        // Three back-to-back commands with a random-latency processor
        done_seen = 0;
        tick(1'b1, {1'b0, 10'd1, 9'd2, 10'd3, 9'd4, 12'h123}, 1'b0);
        tick(1'b1, {1'b1, 10'd5, 9'd6, 10'd7, 9'd8, 12'h040}, 1'b0);
        tick(1'b1, {1'b0, 10'd9, 9'd9, 10'd2, 9'd1, 12'h0F0}, 1'b0);
        drain(200);
        check("t2_done_pulses", 64'(done_seen), 64'd3);

        // Overfill while the processor stalls
        done_seen = 0;
        acc = 0;
        pend = rnd_cmd();
        for (int i = 0; i < 24; i++) begin
            tick(1'b1, pend, 1'b0);
            if (last_push) begin
                acc++;
                pend = rnd_cmd();
            end
        end
        check("t3_count_full", 64'(count), 64'(DEPTH));
        check("t3_ready_low", 64'(cmd_ready), 64'd0);
        check("t3_accepted", 64'(acc), 64'(DEPTH + 1));
        tick(1'b1, pend, 1'b0);
        check("t3_held", 64'(last_push), 64'd0);
        drain(500);
        check("t3_done_pulses", 64'(done_seen), 64'(DEPTH + 1));

        // Finish held high throughout
        done_seen = 0;
        for (int i = 0; i < 4; i++) tick(1'b1, rnd_cmd(), 1'b1);
        repeat (20) tick(1'b0, '0, 1'b1);
        check("t4_done_pulses", 64'(done_seen), 64'd4);

        // Push and pop on the same edge at count 4
        for (int i = 0; i < 5; i++) tick(1'b1, rnd_cmd(), 1'b0);
        check("t5_count4", 64'(count), 64'd4);
        tick(1'b0, '0, 1'b1);
        tick(1'b0, '0, 1'b0);
        tick(1'b1, rnd_cmd(), 1'b0);
        check("t5_pp_count", 64'(count), 64'd4);
        check("t5_pp_en", 64'(gp_en), 64'd1);
        drain(300);

        // Reset mid-ISSUE with 5 queued, stale finish afterwards
        for (int i = 0; i < 6; i++) tick(1'b1, rnd_cmd(), 1'b0);
        check("t6_count5", 64'(count), 64'd5);
        do_reset();
        repeat (10) tick(1'b0, '0, 1'b1);
        check("t6_no_stale", 64'(gp_en), 64'd0);

        // Random traffic, well past pointer wrap
        done_seen = 0;
        total_acc = 0;
        iter = 0;
        while ((total_acc < 60 || iter < 400) && iter < 3000) begin
            tick(($urandom_range(0, 9) < 7), rnd_cmd(), ($urandom_range(0, 9) < 3));
            if (last_push) total_acc++;
            iter++;
        end
        drain(1000);
        check("t7_done_pulses", 64'(done_seen), 64'(total_acc));
        check("t7_idle", 64'(idle), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
